conv_window_generator: RTL and testbench
========================================

# conv_window_generator

Streaming 3x3 window generator feeding the conv2d `multiplier_adder` datapath. It accepts a raster-order pixel stream (row-major, one pixel per handshake) and buffers the two previous image rows in internal line buffers. It emits one full 3x3 window per valid (unpadded) output position on the nine pixel ports that map one-to-one onto the multiply-adder's `x00..x22` inputs. It is the producer end of the window interface the multiply-adder consumes.

## Interface
- `PIXEL_WIDTH`, 16, signed pixel width; identical to the multiply-adder's `PIXEL_WIDTH`.
- `IMG_WIDTH`, 8, pixels per row; legal values >= 3.
- `IMG_HEIGHT`, 8, rows per frame; legal values >= 3.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_pixel` is valid.
- `in_ready`  out  1  block can accept a pixel.
- `in_pixel`  in  `PIXEL_WIDTH`  signed pixel, raster order.
- `out_valid`  out  1  window on `x00..x22` is valid.
- `out_ready`  in  1  downstream accepts the window.
- `x00`,`x01`,`x02`,`x10`,`x11`,`x12`,`x20`,`x21`,`x22`  out  `PIXEL_WIDTH` each  signed window. Row digit: 0 = oldest row. Column digit: 0 = leftmost column.
- `out_last`  out  1  present only with `WIN_LAST_EN`. Marks the final window of a frame.

## Operation
- A pixel is accepted when `in_valid && in_ready`. Only accepted pixels advance state.
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) hold the position of the next pixel.
  - `col` wraps to 0 after IMG_WIDTH-1, and `row` increments on that wrap.
  - After pixel (IMG_HEIGHT-1, IMG_WIDTH-1), both counters return to 0. The next pixel starts a new frame with no gap cycle.
- Line buffers:
  - Two IMG_WIDTH-deep buffers, implemented as registers or a shift structure.
  - Line buffer A holds row r-1 and line buffer B holds row r-2, both at the current column.
  - On accept at column c: B[c] <= A[c], and A[c] <= in_pixel.
- Window shift:
  - On each accept, columns 0 and 1 of the window take the old columns 1 and 2.
  - Column 2 is loaded with (B[c], A[c], in_pixel) into (`x02`, `x12`, `x22`).
- Window validity:
  - Accepting pixel (r, c) with r >= 2 and c >= 2 sets `out_valid` on the next cycle.
  - The window then holds pixel (r-2+i, c-2+j) on port `xij`.
  - Accepts with r < 2 or c < 2 update state but produce no window.
  - There are exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows per frame. No window spans a row wrap or a frame boundary.
- Handshake:
  - `in_ready = rst_n && (!out_valid || out_ready)`.
  - While `out_valid && !out_ready`, the window outputs, `out_valid`, counters and line buffers all hold. No pixel is accepted.
  - A window consumed with no new window-producing accept in the same cycle clears `out_valid` on the next cycle.
- Arithmetic: none. Pixels pass through bit-exact, signed, with no truncation or extension.
- Stale line-buffer contents from a previous frame are never exposed, because the validity rule excludes them. Line buffers are therefore not cleared at frame start.

## Timing
- Reset (asynchronous assert, synchronous release):
  - `out_valid` = 0, all `xij` = 0, `out_last` = 0.
  - `col` = 0, `row` = 0, line buffers = 0.
  - `in_ready` = 0 while `rst_n` is low.
- Latency: 1 cycle from the accepting edge of pixel (r, c) to the corresponding `out_valid`.
- Throughput: 1 pixel per cycle with `out_ready` held high. Backpressure propagates combinationally to `in_ready`.
- Reset asserted mid-frame:
  - The partial frame is discarded.
  - The first pixel after release is position (0, 0).
  - No window is emitted until (2, 2) of the new frame.

## Configuration
- `CONV_WIN_LAST_EN` defined:
  - Port `out_last` exists.
  - It is asserted together with `out_valid` for the window produced by pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - It holds with the window under backpressure and is 0 otherwise.
- `CONV_WIN_LAST_EN` not defined: no `out_last` port and no associated logic. All other behaviour is identical.

## Test plan
- **Basic 4x4 frame.** `IMG_WIDTH` = `IMG_HEIGHT` = 4, pixel = 10*r + c, `out_ready` = 1.
  - Exactly 4 windows appear.
  - First window: x00 = 0, x01 = 1, x02 = 2, x10 = 10, x11 = 11, x12 = 12, x20 = 20, x21 = 21, x22 = 22. It appears one cycle after pixel 22 is accepted.
  - Last window: x00 = 11 through x22 = 33.
- **Backpressure.** Same frame, `out_ready` = 0 for 5 cycles when the first window is valid.
  - `in_ready` is 0 throughout and the window is stable.
  - No pixel is lost, and the remaining 3 windows are correct.
- **Back-to-back frames.** Two 4x4 frames with no idle cycle; frame 2 values are 100 + 10*r + c.
  - 8 windows in total.
  - Frame 2's first window is 100, 101, 102 / 110, 111, 112 / 120, 121, 122.
  - No window mixes frames.
- **Reset mid-frame.** Assert `rst_n` = 0 after 7 pixels.
  - `out_valid` = 0, all `xij` = 0, `in_ready` = 0 during reset.
  - A full frame afterwards yields the same 4 windows as the basic 4x4 test.
- **Signed pass-through.** Frame with pixel (2, 2) = 16'h8000 and (0, 0) = 16'hFFFF.
  - First window has x22 = -32768 and x00 = -1, unmodified.
- **Last-window flag.** With `CONV_WIN_LAST_EN` on the basic 4x4 stimulus, `out_last` = 1 only on the 4th window.

Source files
------------

// File: rtl/conv_window_generator_if.sv
// ============================================================================
// Module  : conv_window_generator_if
// Brief   : Pixel-in / 3x3-window-out handshake bundle for conv_window_generator.
//           out_last exists only when CONV_WIN_LAST_EN is defined.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_window_generator_if #(
    parameter int PIXEL_WIDTH = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [PIXEL_WIDTH-1:0] in_pixel;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [PIXEL_WIDTH-1:0] x00, x01, x02;
    logic signed [PIXEL_WIDTH-1:0] x10, x11, x12;
    logic signed [PIXEL_WIDTH-1:0] x20, x21, x22;
`ifdef CONV_WIN_LAST_EN
    logic                          out_last;
`endif

    // Master: pixel source and window sink surrounding the generator.
    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid,
        input  x00, x01, x02, x10, x11, x12, x20, x21, x22
`ifdef CONV_WIN_LAST_EN
        , input out_last
`endif
    );

    // Slave: the window generator itself.
    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid,
        output x00, x01, x02, x10, x11, x12, x20, x21, x22
`ifdef CONV_WIN_LAST_EN
        , output out_last
`endif
    );
endinterface

`default_nettype wire

// File: rtl/conv_window_generator.sv
// ============================================================================
// Module  : conv_window_generator
// Brief   : Streaming 3x3 window generator with two line buffers; one window
//           per unpadded position. Optional macro: CONV_WIN_LAST_EN (out_last).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_generator #(
    parameter int PIXEL_WIDTH = 16,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    conv_window_generator_if.slave win_if
);
    localparam int c_col_w = $clog2(IMG_WIDTH);
    localparam int c_row_w = $clog2(IMG_HEIGHT);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(IMG_WIDTH - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(IMG_HEIGHT - 1);
    localparam logic [c_col_w-1:0] c_col_two  = c_col_w'(2);
    localparam logic [c_row_w-1:0] c_row_two  = c_row_w'(2);

    typedef logic signed [PIXEL_WIDTH-1:0] pix_t;

    logic [c_col_w-1:0] col_q, col_d;
    logic [c_row_w-1:0] row_q, row_d;
    logic               out_valid_q, out_valid_d;
    pix_t               lb_a_q [IMG_WIDTH];
    pix_t               lb_a_d [IMG_WIDTH];
    pix_t               lb_b_q [IMG_WIDTH];
    pix_t               lb_b_d [IMG_WIDTH];
    pix_t               win_q  [3][3];
    pix_t               win_d  [3][3];

    logic w_in_ready;
    logic w_accept;
    logic w_win_prod;

    assign w_in_ready = rst_n && (!out_valid_q || win_if.out_ready);
    assign w_accept   = win_if.in_valid && w_in_ready;
    assign w_win_prod = w_accept && (row_q >= c_row_two) && (col_q >= c_col_two);

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        lb_a_d      = lb_a_q;
        lb_b_d      = lb_b_q;
        win_d       = win_q;
        out_valid_d = w_accept ? w_win_prod : (out_valid_q && !win_if.out_ready);

        if (w_accept) begin
            lb_b_d[col_q] = lb_a_q[col_q];
            lb_a_d[col_q] = win_if.in_pixel;

            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            // New right-hand column: row r-2, row r-1, incoming row r.
            win_d[0][2] = lb_b_q[col_q];
            win_d[1][2] = lb_a_q[col_q];
            win_d[2][2] = win_if.in_pixel;

            if (col_q == c_col_last) begin
                col_d = '0;
                row_d = (row_q == c_row_last) ? '0 : row_q + c_row_w'(1);
            end else begin
                col_d = col_q + c_col_w'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < IMG_WIDTH; i++) begin
                lb_a_q[i] <= '0;
                lb_b_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            lb_a_q      <= lb_a_d;
            lb_b_q      <= lb_b_d;
            win_q       <= win_d;
        end
    end

`ifdef CONV_WIN_LAST_EN
    logic last_q, last_d;

    // Flag follows its window: set by the frame's final pixel, held while stalled.
    always_comb begin
        last_d = w_accept ? (w_win_prod && (row_q == c_row_last) && (col_q == c_col_last))
                          : (last_q && out_valid_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    assign win_if.out_last = last_q;
`endif

    assign win_if.in_ready  = w_in_ready;
    assign win_if.out_valid = out_valid_q;
    assign win_if.x00 = win_q[0][0];
    assign win_if.x01 = win_q[0][1];
    assign win_if.x02 = win_q[0][2];
    assign win_if.x10 = win_q[1][0];
    assign win_if.x11 = win_q[1][1];
    assign win_if.x12 = win_q[1][2];
    assign win_if.x20 = win_q[2][0];
    assign win_if.x21 = win_q[2][1];
    assign win_if.x22 = win_q[2][2];
endmodule

`default_nettype wire

// File: tb/tb_conv_window_generator.sv
// ============================================================================
// Module  : tb_conv_window_generator
// Brief   : Scoreboard bench for conv_window_generator on a 4x4 image; honours
//           CONV_WIN_LAST_EN for the out_last check.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_window_generator;
    localparam int PW = 16;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WB = 9 * PW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_window_generator_if #(.PIXEL_WIDTH(PW)) wi ();

    conv_window_generator #(
        .PIXEL_WIDTH(PW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .win_if(wi)
    );

    typedef struct {
        logic [WB-1:0] win;
        logic          last;
        int            acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk    = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_win    = 0;
    logic [PW-1:0] img [H][W];
    int          mr       = 0;
    int          mc       = 0;
    bit          stall_req = 1'b0;
    bit          rdy_rand  = 1'b0;
    int          stall_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WB-1:0] cur_win();
        return {wi.x00, wi.x01, wi.x02, wi.x10, wi.x11, wi.x12, wi.x20, wi.x21, wi.x22};
    endfunction

    // Downstream ready: steady, random, or a 5-cycle stall on the next window.
    initial begin
        wi.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_req && wi.out_valid) begin
                stall_req = 1'b0;
                stall_cnt = 5;
            end
            if (stall_cnt > 0) begin
                wi.out_ready = 1'b0;
                stall_cnt--;
            end else if (rdy_rand) begin
                wi.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                wi.out_ready = 1'b1;
            end
        end
    end

    // Monitor: compares each newly presented window with the scoreboard head.
    initial begin
        logic [WB-1:0] held;
        bit   stalled, prev_valid, prev_fire;
        exp_t e;
        held = '0; stalled = 0; prev_valid = 0; prev_fire = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled = 0; prev_valid = 0; prev_fire = 0;
                continue;
            end
            if (stalled) begin
                chk("stall_hold_valid", WB'(wi.out_valid), WB'(1));
                chk("stall_hold_window", cur_win(), held);
            end
            if (wi.out_valid && (!prev_valid || prev_fire)) begin
                chk("window_expected", WB'(exp_q.size() != 0), WB'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    chk("window_latency", WB'(cyc), WB'(e.acc_cyc + 1));
                    chk("window_data", cur_win(), e.win);
`ifdef CONV_WIN_LAST_EN
                    chk("out_last", WB'(wi.out_last), WB'(e.last));
`endif
                end
            end
            if (wi.out_valid && !wi.out_ready)
                chk("in_ready_backpressure", WB'(wi.in_ready), WB'(0));
            if (wi.out_valid && wi.out_ready) begin
                n_win++;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            stalled    = wi.out_valid && !wi.out_ready;
            held       = cur_win();
            prev_valid = wi.out_valid;
            prev_fire  = wi.out_valid && wi.out_ready;
        end
    end

    // Offer one pixel until accepted; the model records it at the accepting edge.
    task automatic send(input logic [PW-1:0] px);
        int   guard = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            wi.in_valid = 1'b1;
            wi.in_pixel = px;
            #1;
            if (wi.in_ready) break;
            guard++;
            if (guard > 200) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stuck at %0b, required 1", wi.in_ready);
                return;
            end
        end
        img[mr][mc] = px;
        if (mr >= 2 && mc >= 2) begin
            e.win     = '0;
            e.last    = (mr == H - 1) && (mc == W - 1);
            e.acc_cyc = cyc;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[(8 - (i * 3 + j)) * PW +: PW] = img[mr - 2 + i][mc - 2 + j];
            exp_q.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        wi.in_valid = 1'b0;
        wi.in_pixel = PW'($urandom);
    endtask

    // kind 0: base+10r+c, kind 1: random, kind 2: random with signed corner values.
    task automatic run_frame(input int kind, input int base, input bit gaps);
        logic [PW-1:0] px;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (kind == 0)      px = PW'(base + 10 * r + c);
                else                px = PW'($urandom);
                if (kind == 2 && r == 0 && c == 0) px = 16'hFFFF;
                if (kind == 2 && r == 2 && c == 2) px = 16'h8000;
                if (gaps && $urandom_range(0, 3) == 0) idle();
                send(px);
            end
        end
    endtask

    task automatic drain(input string name, input int w0, input int n_exp);
        int g = 0;
        @(negedge clk);
        wi.in_valid = 1'b0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_queue_empty"}, WB'(exp_q.size()), WB'(0));
        chk({name, "_window_count"}, WB'(n_win - w0), WB'(n_exp));
    endtask

    initial begin
        int w0;
        wi.in_valid = 1'b0;
        wi.in_pixel = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_out_valid", WB'(wi.out_valid), WB'(0));
        chk("reset_window", cur_win(), '0);
        chk("reset_in_ready", WB'(wi.in_ready), WB'(0));
`ifdef CONV_WIN_LAST_EN
        chk("reset_out_last", WB'(wi.out_last), WB'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        w0 = n_win; run_frame(0, 0, 0); drain("basic", w0, 4);

        w0 = n_win; stall_req = 1'b1; run_frame(0, 0, 0); drain("backpressure", w0, 4);

        w0 = n_win; run_frame(0, 0, 0); run_frame(0, 100, 0); drain("back_to_back", w0, 8);

        for (int k = 0; k < 7; k++) send(PW'($urandom));
        @(negedge clk);
        wi.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", WB'(wi.out_valid), WB'(0));
        chk("midreset_window", cur_win(), '0);
        chk("midreset_in_ready", WB'(wi.in_ready), WB'(0));
        chk("midreset_no_pending", WB'(exp_q.size()), WB'(0));
        exp_q.delete();
        mr = 0;
        mc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        w0 = n_win; run_frame(0, 0, 0); drain("after_reset", w0, 4);

        w0 = n_win; run_frame(2, 0, 0); drain("signed", w0, 4);

        rdy_rand = 1'b1;
        w0 = n_win;
        for (int f = 0; f < 6; f++) run_frame((f % 2 == 0) ? 1 : 2, 0, 1);
        drain("random", w0, 24);
        rdy_rand = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
